multicycle_ctrl: RTL and testbench

Multicycle control FSM for the RV32I core: it is the driving end of the ALU interface. It decodes the instruction register, sequences fetch, decode, execute, memory and writeback, produces `aluctrl` and operand selects for the ALU, and consumes the ALU `eq` flag to resolve branches. It also owns the memory-ready handshake and the per-state write strobes for the PC, IR, register file and data memory.

---
 rtl/multicycle_ctrl_pkg.sv | 22 ++
 rtl/multicycle_ctrl_if.sv | 19 +
 rtl/multicycle_ctrl_alu_decoder.sv | 20 ++
 rtl/multicycle_ctrl.sv | 114 +++++++++++
 tb/tb_multicycle_ctrl.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// ctrl_pkg: shared types and encodings for the multicycle controller and ALU.
// Contents: state enum, ALU operation class, aluctrl codes, mux select encodings, opcodes.
// Build option: CTRL_BNE_EN defined makes branch funct3 001 (bne) legal.
package ctrl_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECUTER, S_EXECUTEI, S_LUI, S_ALUWB, S_BRANCH, S_JAL, S_TRAP
  } state_t;
  typedef enum logic [1:0] {CLS_ADD, CLS_SUB, CLS_FUNCT} alu_cls_t;
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3, ALU_SLT = 4'd5;
  localparam logic [1:0] SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_RS1 = 2'b10, SRCA_ZERO = 2'b11;
  localparam logic [1:0] SRCB_RS2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00, RES_RDATA = 2'b01, RES_ALU = 2'b10;
  localparam logic [2:0] IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_J = 3'b011, IMM_U = 3'b100;
  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011, OP_I = 7'b0010011;
  localparam logic [6:0] OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_LUI = 7'b0110111;
`ifdef CTRL_BNE_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif
endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: controller <-> datapath/memory bundle.
// master (controller): in instr, eq, mem_ready; out aluctrl, alusrca, alusrcb, resultsrc, immsrc,
//   adrsrc, pcwrite, irwrite, regwrite, memwrite, illegal. slave is the mirror image.
interface multicycle_ctrl_if #(parameter int D_WIDTH = 32);
  logic [D_WIDTH-1:0] instr;
  logic eq, mem_ready;
  logic [3:0] aluctrl;
  logic [1:0] alusrca, alusrcb, resultsrc;
  logic [2:0] immsrc;
  logic adrsrc, pcwrite, irwrite, regwrite, memwrite, illegal;
  modport master(
    input instr, eq, mem_ready,
    output aluctrl, alusrca, alusrcb, resultsrc, immsrc, adrsrc, pcwrite, irwrite, regwrite, memwrite, illegal
  );
  modport slave(
    output instr, eq, mem_ready,
    input aluctrl, alusrca, alusrcb, resultsrc, immsrc, adrsrc, pcwrite, irwrite, regwrite, memwrite, illegal
  );
endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// alu_decoder: maps operation class and funct fields to aluctrl, flags unsupported funct3.
// Ports: cls_i, funct3_i, funct7b5_i, opcode_i in; aluctrl_o, illegal_o out.
// illegal_o depends only on the instruction so DECODE can dispatch to TRAP; bne legality follows CTRL_BNE_EN.
module alu_decoder import ctrl_pkg::*; (
  input  alu_cls_t   cls_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic [6:0] opcode_i,
  output logic [3:0] aluctrl_o,
  output logic       illegal_o
);
  logic [3:0] fn;
  assign fn = funct3_i == 3'b010 ? ALU_SLT :
              funct3_i == 3'b110 ? ALU_OR :
              funct3_i == 3'b111 ? ALU_AND :
              (opcode_i == OP_R && funct7b5_i) ? ALU_SUB : ALU_ADD;
  assign aluctrl_o = cls_i == CLS_FUNCT ? fn : cls_i == CLS_SUB ? ALU_SUB : ALU_ADD;
  assign illegal_o = ((opcode_i == OP_R || opcode_i == OP_I) && !(funct3_i inside {3'b000, 3'b010, 3'b110, 3'b111})) ||
                     (opcode_i == OP_BR && !(funct3_i == 3'b000 || (BNE_EN && funct3_i == 3'b001)));
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: RV32I multicycle control FSM driving the ALU, muxes and write strobes.
// Ports: clk, rst_n (async, active low), bus (multicycle_ctrl_if.master).
// Build option: CTRL_BNE_EN enables bne (BRANCH then writes the PC on !eq).
module multicycle_ctrl import ctrl_pkg::*; #(parameter int D_WIDTH = 32) (
  input logic clk,
  input logic rst_n,
  multicycle_ctrl_if.master bus
);
  state_t state_q, state_d;
  alu_cls_t cls;
  logic [6:0] op;
  logic [2:0] f3;
  logic f_ill, unused;
  assign op = bus.instr[6:0];
  assign f3 = bus.instr[14:12];
  assign unused = ^bus.instr[D_WIDTH-1:0];
  assign cls = (state_q == S_EXECUTER || state_q == S_EXECUTEI) ? CLS_FUNCT :
               state_q == S_BRANCH ? CLS_SUB : CLS_ADD;
  alu_decoder u_dec (
    .cls_i(cls),
    .funct3_i(f3),
    .funct7b5_i(bus.instr[30]),
    .opcode_i(op),
    .aluctrl_o(bus.aluctrl),
    .illegal_o(f_ill)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= S_IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    bus.alusrca = SRCA_PC;
    bus.alusrcb = SRCB_RS2;
    bus.resultsrc = RES_ALUOUT;
    bus.adrsrc = 1'b0;
    bus.pcwrite = 1'b0;
    bus.irwrite = 1'b0;
    bus.regwrite = 1'b0;
    bus.memwrite = 1'b0;
    bus.illegal = state_q == S_TRAP;
    bus.immsrc = op == OP_SW ? IMM_S : op == OP_BR ? IMM_B : op == OP_JAL ? IMM_J : op == OP_LUI ? IMM_U : IMM_I;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        bus.alusrcb = SRCB_FOUR;
        bus.resultsrc = RES_ALU;
        bus.irwrite = bus.mem_ready;
        bus.pcwrite = bus.mem_ready;
        state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        bus.alusrca = SRCA_OLDPC;
        bus.alusrcb = SRCB_IMM;
        state_d = (op == OP_LW || op == OP_SW) ? S_MEMADR :
                  f_ill ? S_TRAP :
                  op == OP_R ? S_EXECUTER :
                  op == OP_I ? S_EXECUTEI :
                  op == OP_BR ? S_BRANCH :
                  op == OP_JAL ? S_JAL :
                  op == OP_LUI ? S_LUI : S_TRAP;
      end
      S_MEMADR: begin
        bus.alusrca = SRCA_RS1;
        bus.alusrcb = SRCB_IMM;
        state_d = op == OP_LW ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        bus.adrsrc = 1'b1;
        state_d = bus.mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        bus.resultsrc = RES_RDATA;
        bus.regwrite = 1'b1;
        state_d = S_FETCH;
      end
      S_MEMWRITE: begin
        bus.adrsrc = 1'b1;
        bus.memwrite = 1'b1;
        state_d = bus.mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER: begin
        bus.alusrca = SRCA_RS1;
        state_d = S_ALUWB;
      end
      S_EXECUTEI: begin
        bus.alusrca = SRCA_RS1;
        bus.alusrcb = SRCB_IMM;
        state_d = S_ALUWB;
      end
      S_LUI: begin
        bus.alusrca = SRCA_ZERO;
        bus.alusrcb = SRCB_IMM;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        bus.regwrite = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        bus.alusrca = SRCA_RS1;
        bus.pcwrite = (BNE_EN && f3 == 3'b001) ? !bus.eq : bus.eq;
        state_d = S_FETCH;
      end
      S_JAL: begin
        bus.alusrca = SRCA_OLDPC;
        bus.alusrcb = SRCB_FOUR;
        bus.pcwrite = 1'b1;
        state_d = S_ALUWB;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed self-checking bench for multicycle_ctrl.
module tb_multicycle_ctrl;
  logic clk, rst_n;
  int total = 0, bad = 0;
  localparam logic [31:0] R_SUB = 32'h40208033, LW = 32'h00412083, SW = 32'h0020A223;
  localparam logic [31:0] BEQ = 32'h00208063, BNE = 32'h00209063, JAL = 32'h0000006F, LUI = 32'h000010B7;
  logic [31:0] alu_ins [9] = '{32'h00208033, 32'h0020A033, 32'h0020E033, 32'h0020F033,
                               32'h00508093, 32'h0050A093, 32'h0050E093, 32'h0050F093, 32'h40008093};
  int alu_exp [9] = '{0, 5, 3, 2, 0, 5, 3, 2, 0};
  int alu_b [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 1};
  multicycle_ctrl_if #(.D_WIDTH(32)) bus();
  multicycle_ctrl #(.D_WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input int a, input int sa, input int sb, input int rs, input int im,
                     input int ad, input int pw, input int iw, input int rw, input int mw, input int il);
    logic [18:0] got, exp;
    #1;
    got = {bus.aluctrl, bus.alusrca, bus.alusrcb, bus.resultsrc, bus.immsrc, bus.adrsrc,
           bus.pcwrite, bus.irwrite, bus.regwrite, bus.memwrite, bus.illegal};
    exp = {4'(a), 2'(sa), 2'(sb), 2'(rs), 3'(im), 1'(ad), 1'(pw), 1'(iw), 1'(rw), 1'(mw), 1'(il)};
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask
  task automatic trap(input string tag, input logic [31:0] ins, input int imm);
    bus.instr = ins;
    tick;
    chk({tag, ".decode"}, 0, 1, 1, 0, imm, 0, 0, 0, 0, 0, 0);
    bus.eq = 1'b1;
    for (int k = 0; k < 11; k++) begin
      tick;
      chk({tag, ".trap"}, 0, 0, 0, 0, imm, 0, 0, 0, 0, 0, 1);
    end
    rst_n = 1'b0;
    chk({tag, ".rst"}, 0, 0, 0, 0, imm, 0, 0, 0, 0, 0, 0);
    tick;
    rst_n = 1'b1;
    bus.eq = 1'b0;
    tick;
  endtask
  initial begin
    rst_n = 1'b0;
    bus.mem_ready = 1'b1;
    bus.eq = 1'b0;
    bus.instr = '0;
    tick;
    chk("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    rst_n = 1'b1;
    chk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.instr = R_SUB;
    tick;
    chk("fetch", 0, 0, 2, 2, 0, 0, 1, 1, 0, 0, 0);
    tick;
    chk("sub.decode", 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    chk("sub.exec", 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    chk("sub.aluwb", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    tick;
    bus.instr = LW;
    chk("lw.fetch", 0, 0, 2, 2, 0, 0, 1, 1, 0, 0, 0);
    tick;
    chk("lw.decode", 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    chk("lw.memadr", 0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    bus.mem_ready = 1'b0;
    chk("lw.memread0", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    tick;
    chk("lw.memread1", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    tick;
    bus.mem_ready = 1'b1;
    chk("lw.memread2", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    tick;
    chk("lw.memwb", 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
    tick;
    bus.mem_ready = 1'b0;
    bus.instr = BEQ;
    chk("fetch.wait0", 0, 0, 2, 2, 2, 0, 0, 0, 0, 0, 0);
    tick;
    chk("fetch.wait1", 0, 0, 2, 2, 2, 0, 0, 0, 0, 0, 0);
    bus.mem_ready = 1'b1;
    bus.eq = 1'b1;
    chk("fetch.go", 0, 0, 2, 2, 2, 0, 1, 1, 0, 0, 0);
    tick;
    chk("beq.decode", 0, 1, 1, 0, 2, 0, 0, 0, 0, 0, 0);
    tick;
    chk("beq.taken", 1, 2, 0, 0, 2, 0, 1, 0, 0, 0, 0);
    tick;
    bus.eq = 1'b0;
    chk("beq.fetch", 0, 0, 2, 2, 2, 0, 1, 1, 0, 0, 0);
    tick;
    tick;
    chk("beq.nottaken", 1, 2, 0, 0, 2, 0, 0, 0, 0, 0, 0);
    tick;
    bus.instr = JAL;
    bus.eq = 1'b1;
    chk("jal.fetch", 0, 0, 2, 2, 3, 0, 1, 1, 0, 0, 0);
    tick;
    chk("jal.decode", 0, 1, 1, 0, 3, 0, 0, 0, 0, 0, 0);
    tick;
    chk("jal", 0, 1, 2, 0, 3, 0, 1, 0, 0, 0, 0);
    tick;
    chk("jal.aluwb", 0, 0, 0, 0, 3, 0, 0, 0, 1, 0, 0);
    tick;
    bus.instr = LUI;
    bus.eq = 1'b0;
    tick;
    tick;
    chk("lui", 0, 3, 1, 0, 4, 0, 0, 0, 0, 0, 0);
    tick;
    chk("lui.aluwb", 0, 0, 0, 0, 4, 0, 0, 0, 1, 0, 0);
    tick;
    for (int i = 0; i < 9; i++) begin
      bus.instr = alu_ins[i];
      chk("alu.fetch", 0, 0, 2, 2, 0, 0, 1, 1, 0, 0, 0);
      tick;
      chk("alu.decode", 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      tick;
      chk("alu.exec", alu_exp[i], 2, alu_b[i], 0, 0, 0, 0, 0, 0, 0, 0);
      tick;
      chk("alu.aluwb", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      tick;
    end
    bus.instr = SW;
    chk("sw.fetch", 0, 0, 2, 2, 1, 0, 1, 1, 0, 0, 0);
    tick;
    tick;
    chk("sw.memadr", 0, 2, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    tick;
    bus.mem_ready = 1'b0;
    chk("sw.wait", 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0);
    tick;
    bus.mem_ready = 1'b1;
    chk("sw.done", 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0);
    tick;
    chk("sw.fetch2", 0, 0, 2, 2, 1, 0, 1, 1, 0, 0, 0);
    tick;
    tick;
    tick;
    bus.mem_ready = 1'b0;
    chk("sw.memwrite", 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0);
    rst_n = 1'b0;
    chk("sw.async_rst", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    tick;
    rst_n = 1'b1;
    bus.mem_ready = 1'b1;
    chk("sw.idle", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    tick;
`ifdef CTRL_BNE_EN
    bus.instr = BNE;
    bus.eq = 1'b1;
    tick;
    tick;
    chk("bne.eq", 1, 2, 0, 0, 2, 0, 0, 0, 0, 0, 0);
    bus.eq = 1'b0;
    chk("bne.ne", 1, 2, 0, 0, 2, 0, 1, 0, 0, 0, 0);
    tick;
`else
    trap("bne", BNE, 2);
`endif
    trap("badop", 32'h0000007F, 0);
    trap("xori", 32'h0050C093, 0);
    chk("end.fetch", 0, 0, 2, 2, 0, 0, 1, 1, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
